layer_mixer: RTL and testbench
==============================

LAYER_MIXER -- requirements
Module: layer_mixer

Interface
REQ-001 Parameter NUM_LAYERS, default 5, number of drawable layers (range 2..8).
REQ-002 Parameter COLOR_W, default 3, colour bits per layer and output.
REQ-003 Parameter MENU_LAYER, default 4, the only layer shown in menu mode.
REQ-004 Parameter BLINK_FRAMES, default 16, frames per blink half-period (range 1..255).
REQ-005 clock  input  1  system clock; all logic on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 visible  input  1  pixel is inside the active display area.
REQ-008 frame_start  input  1  one-cycle pulse at the start of each frame.
REQ-009 menu_mode  input  1  dead/init/win screen active.
REQ-010 layer_en  input  NUM_LAYERS  bit i high: layer i has a pixel here.
REQ-011 layer_rgb  input  NUM_LAYERS*COLOR_W  packed colours; layer i at bits [i*COLOR_W +: COLOR_W].
REQ-012 blink_mask  input  NUM_LAYERS  bit i high: layer i blinks.
REQ-013 cfg_we  input  1  write-strobe for the priority table.
REQ-014 cfg_slot  input  3  priority slot to write (slot 0 = highest priority).
REQ-015 cfg_layer  input  3  layer index placed in cfg_slot.
REQ-016 oRGB  output  COLOR_W  composited pixel colour.
REQ-017 o_hit  output  1  high when some layer won the pixel.
REQ-018 o_layer  output  3  index of the winning layer; 0 when o_hit is low.

Function
REQ-019 Two priority tables of NUM_LAYERS 3-bit entries SHALL exist: shadow (written by cfg) and active (used for mixing).
REQ-020 cfg_we with cfg_slot < NUM_LAYERS SHALL write cfg_layer into shadow[cfg_slot] on the same edge; a cfg_slot >= NUM_LAYERS, or a cfg_layer >= NUM_LAYERS, SHALL cause the write to be ignored.
REQ-021 On frame_start the active table SHALL load the whole shadow table; a cfg_we coincident with frame_start SHALL be included in that load.
REQ-022 Layer i is eligible when layer_en[i] is high, it is not blink-suppressed (REQ-029), and, in menu_mode, i == MENU_LAYER.
REQ-023 The winner SHALL be the entry of the lowest-numbered active slot whose layer is eligible; duplicate table entries are legal, and a layer absent from the table SHALL never win.
REQ-024 Pipeline: stage 1 registers winner index, hit and colour; stage 2 applies blanking and drives the outputs; latency SHALL be exactly 2 cycles from inputs to outputs.
REQ-025 visible SHALL be delayed with the pixel; when the delayed visible is low, oRGB, o_hit and o_layer SHALL be 0.
REQ-026 With no eligible layer, oRGB = 0, o_hit = 0 and o_layer = 0.
REQ-027 menu_mode SHALL be sampled per pixel with no frame alignment.
REQ-028 Blink state: an 8-bit frame counter and a phase bit; each frame_start increments the counter; at BLINK_FRAMES-1 the counter wraps to 0 and phase toggles.
REQ-029 While phase = 1, layers with blink_mask set SHALL be ineligible.

Reset
REQ-030 reset SHALL clear oRGB, o_hit, o_layer, both pipeline stages, the frame counter and phase to 0.
REQ-031 reset SHALL load both tables with slot i = layer i, giving the identity priority.
REQ-032 reset SHALL take precedence over cfg_we and frame_start in the same cycle; outputs SHALL be 0 for 2 cycles after release.

Configuration
REQ-033 Macro LAYER_MIXER_BLINK_EN: when defined, REQ-028 and REQ-029 apply; when undefined, no counter or phase is built, blink_mask is ignored, and no layer is ever blink-suppressed.

Verification
REQ-034 Identity table, layer_en=5'b00110, layer 1 rgb=3'b010, visible=1 -> 2 cycles later oRGB=3'b010, o_layer=1, o_hit=1.
REQ-035 Write shadow[0]=3 mid-frame, then pulse frame_start, with layer_en=5'b01010 and layer 3 rgb=3'b101 -> before frame_start o_layer=1; after it o_layer=3, oRGB=3'b101.
REQ-036 menu_mode=1, layer_en=5'b11111, layer 4 rgb=3'b111 -> oRGB=3'b111, o_layer=4; with layer_en[4]=0 -> oRGB=0, o_hit=0.
REQ-037 Visible low for 1 cycle, all layers enabled -> exactly one output cycle of 0, aligned 2 cycles later.
REQ-038 LAYER_MIXER_BLINK_EN defined, BLINK_FRAMES=2, blink_mask[0]=1, layer_en=5'b00001 -> o_hit=1 in frames 0-1, 0 in frames 2-3, 1 in frames 4-5.
REQ-039 cfg_we with cfg_slot=6 and NUM_LAYERS=5, then frame_start -> active table unchanged and outputs unchanged.

Source files
------------

// File: rtl/layer_mixer_if.sv
// Pixel-mixer bus: per-pixel layer inputs, priority-table config port and composited outputs.
interface layer_mixer_if #(
    parameter int NUM_LAYERS = 5,
    parameter int COLOR_W    = 3
);
    logic                          visible;
    logic                          frame_start;
    logic                          menu_mode;
    logic [NUM_LAYERS-1:0]         layer_en;
    logic [NUM_LAYERS*COLOR_W-1:0] layer_rgb;
    logic [NUM_LAYERS-1:0]         blink_mask;
    logic                          cfg_we;
    logic [2:0]                    cfg_slot;
    logic [2:0]                    cfg_layer;
    logic [COLOR_W-1:0]            oRGB;
    logic                          o_hit;
    logic [2:0]                    o_layer;

    modport master (
        output visible, frame_start, menu_mode, layer_en, layer_rgb, blink_mask,
               cfg_we, cfg_slot, cfg_layer,
        input  oRGB, o_hit, o_layer
    );

    modport slave (
        input  visible, frame_start, menu_mode, layer_en, layer_rgb, blink_mask,
               cfg_we, cfg_slot, cfg_layer,
        output oRGB, o_hit, o_layer
    );
endinterface

// File: rtl/layer_mixer.sv
// Priority-table layer compositor with double-buffered table and 2-cycle pixel pipeline.
// Define LAYER_MIXER_BLINK_EN to build the frame-counted blink suppression.
module layer_mixer #(
    parameter int NUM_LAYERS   = 5,
    parameter int COLOR_W      = 3,
    parameter int MENU_LAYER   = 4,
    parameter int BLINK_FRAMES = 16
) (
    input  logic          clock,
    input  logic          reset,
    layer_mixer_if.slave  bus
);

    localparam logic [3:0] NL       = 4'(NUM_LAYERS);
    localparam logic [2:0] MENU_IDX = 3'(MENU_LAYER);

    logic [2:0] shadow_tbl [NUM_LAYERS];
    logic [2:0] shadow_nxt [NUM_LAYERS];
    logic [2:0] active_tbl [NUM_LAYERS];
    logic       cfg_ok;

    // Out-of-range slots or layers are dropped so the tables only ever hold valid layers.
    assign cfg_ok = bus.cfg_we && ({1'b0, bus.cfg_slot} < NL) && ({1'b0, bus.cfg_layer} < NL);

    always_comb begin
        for (int s = 0; s < NUM_LAYERS; s++) shadow_nxt[s] = shadow_tbl[s];
        if (cfg_ok) shadow_nxt[bus.cfg_slot] = bus.cfg_layer;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int s = 0; s < NUM_LAYERS; s++) begin
                shadow_tbl[s] <= 3'(s);
                active_tbl[s] <= 3'(s);
            end
        end else begin
            for (int s = 0; s < NUM_LAYERS; s++) shadow_tbl[s] <= shadow_nxt[s];
            if (bus.frame_start) begin
                for (int s = 0; s < NUM_LAYERS; s++) active_tbl[s] <= shadow_nxt[s];
            end
        end
    end

    logic [7:0] blink_off;

`ifdef LAYER_MIXER_BLINK_EN
    localparam logic [7:0] WRAP = 8'(BLINK_FRAMES - 1);
    logic [7:0] frame_cnt;
    logic       phase;

    always_ff @(posedge clock) begin
        if (reset) begin
            frame_cnt <= 8'd0;
            phase     <= 1'b0;
        end else if (bus.frame_start) begin
            if (frame_cnt == WRAP) begin
                frame_cnt <= 8'd0;
                phase     <= ~phase;
            end else begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        blink_off = '0;
        if (phase) blink_off[NUM_LAYERS-1:0] = bus.blink_mask;
    end
`else
    logic unused_blink;
    assign unused_blink = ^bus.blink_mask;
    assign blink_off    = '0;
`endif

    logic [7:0]         elig;
    logic [COLOR_W-1:0] rgb_arr [8];
    logic               win_hit;
    logic [2:0]         win_layer;
    logic [COLOR_W-1:0] win_rgb;

    always_comb begin
        elig = '0;
        for (int i = 0; i < 8; i++) rgb_arr[i] = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            elig[i]    = bus.layer_en[i] && !blink_off[i] && (!bus.menu_mode || (3'(i) == MENU_IDX));
            rgb_arr[i] = bus.layer_rgb[i*COLOR_W +: COLOR_W];
        end
    end

    always_comb begin
        win_hit   = 1'b0;
        win_layer = 3'd0;
        for (int s = 0; s < NUM_LAYERS; s++) begin
            if (!win_hit && elig[active_tbl[s]]) begin
                win_hit   = 1'b1;
                win_layer = active_tbl[s];
            end
        end
        win_rgb = win_hit ? rgb_arr[win_layer] : '0;
    end

    logic               vld_p1;
    logic               hit_p1;
    logic [2:0]         layer_p1;
    logic [COLOR_W-1:0] rgb_p1;

    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p1      <= 1'b0;
            hit_p1      <= 1'b0;
            layer_p1    <= 3'd0;
            rgb_p1      <= '0;
            bus.oRGB    <= '0;
            bus.o_hit   <= 1'b0;
            bus.o_layer <= 3'd0;
        end else begin
            // stage 1: winner selection registered
            vld_p1      <= bus.visible;
            hit_p1      <= win_hit;
            layer_p1    <= win_layer;
            rgb_p1      <= win_rgb;
            // stage 2: blanking outside the active area
            bus.oRGB    <= vld_p1 ? rgb_p1 : '0;
            bus.o_hit   <= vld_p1 && hit_p1;
            bus.o_layer <= vld_p1 ? layer_p1 : 3'd0;
        end
    end

endmodule

// File: tb/tb_layer_mixer.sv
// Scoreboard bench for layer_mixer: stimulus pushes expected pixels, a monitor checks them 2 cycles later.
module tb_layer_mixer;

    localparam int NL = 5;
    localparam int CW = 3;
    localparam logic [14:0] PAL = {3'b111, 3'b101, 3'b011, 3'b010, 3'b001};

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    layer_mixer_if #(.NUM_LAYERS(NL), .COLOR_W(CW)) bus ();

    layer_mixer #(
        .NUM_LAYERS(NL), .COLOR_W(CW), .MENU_LAYER(4), .BLINK_FRAMES(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus.slave)
    );

    typedef struct {
        int         cyc;
        logic [2:0] rgb;
        logic       hit;
        logic [2:0] lay;
        string      name;
    } exp_t;

    exp_t q[$];
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic step(input string name, input logic [2:0] e_rgb, input logic e_hit,
                        input logic [2:0] e_lay);
        exp_t e;
        e.cyc  = cyc;
        e.rgb  = e_rgb;
        e.hit  = e_hit;
        e.lay  = e_lay;
        e.name = name;
        q.push_back(e);
        @(negedge clock);
        bus.cfg_we      = 1'b0;
        bus.frame_start = 1'b0;
    endtask

    task automatic cfg(input logic [2:0] slot, input logic [2:0] lay);
        bus.cfg_we    = 1'b1;
        bus.cfg_slot  = slot;
        bus.cfg_layer = lay;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            cyc++;
            #1;
            while (q.size() > 0 && q[0].cyc + 2 <= cyc) begin
                e = q.pop_front();
                n_tests++;
                if ({bus.oRGB, bus.o_hit, bus.o_layer} !== {e.rgb, e.hit, e.lay}) begin
                    n_fail++;
                    $display("FAIL %s: got rgb=%b hit=%b layer=%0d, expected rgb=%b hit=%b layer=%0d",
                             e.name, bus.oRGB, bus.o_hit, bus.o_layer, e.rgb, e.hit, e.lay);
                end
            end
        end
    end

    initial begin
        reset           = 1'b1;
        bus.visible     = 1'b1;
        bus.frame_start = 1'b1;
        bus.menu_mode   = 1'b0;
        bus.layer_en    = 5'b11111;
        bus.layer_rgb   = PAL;
        bus.blink_mask  = 5'b00000;
        bus.cfg_we      = 1'b1;
        bus.cfg_slot    = 3'd0;
        bus.cfg_layer   = 3'd3;

        // reset wins over cfg_we/frame_start and holds outputs low
        step("reset0", 3'b000, 1'b0, 3'd0);
        step("reset1", 3'b000, 1'b0, 3'd0);
        step("reset2", 3'b000, 1'b0, 3'd0);
        reset = 1'b0;

        step("identity_all", 3'b001, 1'b1, 3'd0);
        bus.layer_en = 5'b00110;
        step("layer1_win", 3'b010, 1'b1, 3'd1);
        bus.layer_en = 5'b00000;
        step("no_layer", 3'b000, 1'b0, 3'd0);
        bus.layer_en = 5'b10000;
        step("only4", 3'b111, 1'b1, 3'd4);
        bus.layer_en = 5'b11111;
        bus.visible  = 1'b0;
        step("vis_low", 3'b000, 1'b0, 3'd0);
        bus.visible  = 1'b1;
        step("vis_back", 3'b001, 1'b1, 3'd0);

        bus.layer_en = 5'b01010;
        cfg(3'd0, 3'd3);
        step("cfg_mid", 3'b010, 1'b1, 3'd1);
        step("pre_frame", 3'b010, 1'b1, 3'd1);
        bus.frame_start = 1'b1;
        step("frame_edge", 3'b010, 1'b1, 3'd1);
        step("post_frame", 3'b101, 1'b1, 3'd3);

        // table is now [3,1,2,3,4]: layer 0 absent, layer 3 duplicated
        bus.layer_en = 5'b00001;
        step("absent0", 3'b000, 1'b0, 3'd0);
        bus.layer_en = 5'b00101;
        step("slot2", 3'b011, 1'b1, 3'd2);

        bus.layer_en = 5'b01010;
        cfg(3'd6, 3'd0);
        bus.frame_start = 1'b1;
        step("bad_slot", 3'b101, 1'b1, 3'd3);
        step("bad_slot_after", 3'b101, 1'b1, 3'd3);
        bus.layer_en = 5'b00010;
        cfg(3'd1, 3'd5);
        bus.frame_start = 1'b1;
        step("bad_layer", 3'b010, 1'b1, 3'd1);
        step("bad_layer_after", 3'b010, 1'b1, 3'd1);

        bus.layer_en = 5'b11111;
        cfg(3'd0, 3'd4);
        bus.frame_start = 1'b1;
        step("coinc_edge", 3'b101, 1'b1, 3'd3);
        step("coinc_after", 3'b111, 1'b1, 3'd4);

        bus.menu_mode = 1'b1;
        step("menu_on", 3'b111, 1'b1, 3'd4);
        bus.layer_en  = 5'b01111;
        step("menu_no4", 3'b000, 1'b0, 3'd0);
        bus.menu_mode = 1'b0;
        step("menu_off", 3'b010, 1'b1, 3'd1);

        bus.visible = 1'b0;
        step("idle0", 3'b000, 1'b0, 3'd0);
        step("idle1", 3'b000, 1'b0, 3'd0);
        reset       = 1'b1;
        bus.visible = 1'b1;
        bus.layer_en = 5'b11111;
        step("rereset0", 3'b000, 1'b0, 3'd0);
        step("rereset1", 3'b000, 1'b0, 3'd0);
        reset = 1'b0;
        step("identity_again", 3'b001, 1'b1, 3'd0);

        // blink: BLINK_FRAMES=2 gives hit in frames 0-1, none in 2-3, hit in 4-5
        bus.layer_en   = 5'b00001;
        bus.blink_mask = 5'b00001;
        for (int f = 0; f < 6; f++) begin
            logic h;
`ifdef LAYER_MIXER_BLINK_EN
            h = ((f / 2) % 2) == 0;
`else
            h = 1'b1;
`endif
            step($sformatf("blink_f%0d", f), h ? 3'b001 : 3'b000, h, 3'd0);
            bus.frame_start = 1'b1;
            step($sformatf("blink_edge_f%0d", f), h ? 3'b001 : 3'b000, h, 3'd0);
        end

        bus.visible = 1'b0;
        step("drain0", 3'b000, 1'b0, 3'd0);
        step("drain1", 3'b000, 1'b0, 3'd0);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clock);
        if (q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expected pixels never checked, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
